// File: rtl/uart_pkg.sv
// Shared UART definitions so the transmitter and receiver agree on framing and baud defaults.
package uart_pkg;

  localparam int UART_DATA_BITS          = 8;
  localparam int DEFAULT_BAUD_RATE       = 10000;
  localparam int DEFAULT_CLOCK_FREQUENCY = 250000000;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK_WAIT
  } RxState;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } TxState;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a one-cycle delayed copy for falling-edge detection.
module uart_rx_sync (
  input  logic clk,
  input  logic i_reset_n,
  input  logic rx_async,
  output logic rx_s,
  output logic rx_fall
);

  logic       rx_meta;
  logic       rx_prev;
  logic [1:0] fill;
  logic       armed;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      fill    <= 2'b00;
      armed   <= 1'b0;
    end else begin
      rx_meta <= rx_async;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      fill    <= {fill[0], 1'b1};
      // The reset-to-1 flops would fake a high line; only a genuinely observed high arms edge detection.
      if (fill[1] && rx_s) begin
        armed <= 1'b1;
      end
    end
  end

  assign rx_fall = armed & rx_prev & ~rx_s;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid / frame-error pulses, break hold-off.
//
// state         | meaning
// RX_IDLE       | line idle, waiting for a falling edge
// RX_START      | timing to the middle of the start bit
// RX_DATA       | sampling the 8 data bits, LSB first
// RX_STOP       | sampling the stop bit
// RX_BREAK_WAIT | stop bit was low, waiting for the line to return high
module uart_receiver
  import uart_pkg::*;
#(
  parameter int BAUD_RATE       = DEFAULT_BAUD_RATE,
  parameter int CLOCK_FREQUENCY = DEFAULT_CLOCK_FREQUENCY
) (
  input  logic                      clk,
  input  logic                      i_reset_n,
  input  logic                      i_rx,
  output logic [UART_DATA_BITS-1:0] o_data,
  output logic                      o_data_valid,
  output logic                      o_frame_error,
  output logic                      o_busy
);

  localparam int CYCLES_PER_SAMPLE = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF_SAMPLE       = CYCLES_PER_SAMPLE / 2;
  localparam logic [15:0] BIT_LAST  = 16'(CYCLES_PER_SAMPLE - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_SAMPLE - 1);

  RxState                    state;
  RxState                    state_next;
  logic                      rx_s;
  logic                      rx_fall;
  logic [15:0]               cycle_count;
  logic [2:0]                bit_index;
  logic [UART_DATA_BITS-1:0] shift_reg;

  logic half_done;
  logic bit_done;
  logic count_clear;
  logic index_clear;
  logic index_inc;
  logic shift_en;
  logic load_data;
  logic valid_set;
  logic error_set;

  uart_rx_sync u_sync (
    .clk      (clk),
    .i_reset_n(i_reset_n),
    .rx_async (i_rx),
    .rx_s     (rx_s),
    .rx_fall  (rx_fall)
  );

  assign half_done = (cycle_count == HALF_LAST);
  assign bit_done  = (cycle_count == BIT_LAST);

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= RX_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE: begin
        if (rx_fall) state_next = RX_START;
      end
      RX_START: begin
        if (half_done) state_next = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (bit_done && (bit_index == 3'd7)) state_next = RX_STOP;
      end
      RX_STOP: begin
        if (bit_done) state_next = rx_s ? RX_IDLE : RX_BREAK_WAIT;
      end
      RX_BREAK_WAIT: begin
        if (rx_s) state_next = RX_IDLE;
      end
      default: state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    count_clear = 1'b0;
    index_clear = 1'b0;
    index_inc   = 1'b0;
    shift_en    = 1'b0;
    load_data   = 1'b0;
    valid_set   = 1'b0;
    error_set   = 1'b0;
    o_busy      = (state != RX_IDLE);
    case (state)
      RX_IDLE: begin
        count_clear = rx_fall;
      end
      RX_START: begin
        if (half_done && !rx_s) begin
          count_clear = 1'b1;
          index_clear = 1'b1;
        end
      end
      RX_DATA: begin
        if (bit_done) begin
          shift_en    = 1'b1;
          count_clear = 1'b1;
          index_inc   = (bit_index != 3'd7);
        end
      end
      RX_STOP: begin
        if (bit_done) begin
          load_data = rx_s;
          valid_set = rx_s;
          error_set = ~rx_s;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cycle_count   <= 16'd0;
      bit_index     <= 3'd0;
      shift_reg     <= '0;
      o_data        <= '0;
      o_data_valid  <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      if (count_clear) begin
        cycle_count <= 16'd0;
      end else if (state != RX_IDLE) begin
        cycle_count <= cycle_count + 16'd1;
      end
      if (index_clear) begin
        bit_index <= 3'd0;
      end else if (index_inc) begin
        bit_index <= bit_index + 3'd1;
      end
      if (shift_en) begin
        shift_reg[bit_index] <= rx_s;
      end
      if (load_data) begin
        o_data <= shift_reg;
      end
      o_data_valid  <= valid_set;
      o_frame_error <= error_set;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized frames checked against an expected-event queue built from the frame timing rules.
module tb_uart_receiver;

  localparam int CLK_F = 160;
  localparam int BAUD  = 10;
  localparam int CPS   = CLK_F / BAUD;
  localparam int HALF  = CPS / 2;
  localparam int LAT   = 2 + HALF + 9 * CPS + 1;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    bit         err;
  } ev_t;

  logic       clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_rx = 1'b1;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       o_frame_error;
  logic       o_busy;

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  busy_cnt = 0;
  bit  prev_pulse = 1'b0;
  ev_t exp_q[$];
  ev_t got_q[$];
  logic [7:0] last_good = 8'h00;

  uart_receiver #(.BAUD_RATE(BAUD), .CLOCK_FREQUENCY(CLK_F)) dut (
    .clk          (clk),
    .i_reset_n    (i_reset_n),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_frame_error(o_frame_error),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (o_busy) busy_cnt++;
    if (o_data_valid || o_frame_error) begin
      checks++;
      assert (!(o_data_valid && o_frame_error) && !prev_pulse) else begin
        errors++;
        $error("FAIL pulse_excl observed valid=%0b err=%0b prev=%0b expected single exclusive pulse",
               o_data_valid, o_frame_error, prev_pulse);
      end
      e.cyc  = cyc;
      e.data = o_data;
      e.err  = o_frame_error;
      got_q.push_back(e);
    end
    prev_pulse = o_data_valid | o_frame_error;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok);
    ev_t e;
    e.cyc  = cyc + LAT;
    e.data = b;
    e.err  = !stop_ok;
    exp_q.push_back(e);
    i_rx = 1'b0;
    tick(CPS);
    for (int k = 0; k < 8; k++) begin
      i_rx = b[k];
      tick(CPS);
    end
    i_rx = stop_ok;
    tick(CPS);
  endtask

  task automatic check_events(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_cycle"}, got_q[i].cyc, exp_q[i].cyc);
      chk({tag, "_kind"}, 32'(got_q[i].err), 32'(exp_q[i].err));
      if (!exp_q[i].err) chk({tag, "_data"}, 32'(got_q[i].data), 32'(exp_q[i].data));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    int gap;

    tick(3);
    chk("rst_data", 32'(o_data), 32'h00);
    chk("rst_valid", 32'(o_data_valid), 32'h0);
    chk("rst_err", 32'(o_frame_error), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    i_reset_n = 1'b1;
    tick(10);

    send(8'hA5, 1'b1);
    tick(20);
    check_events("a5");
    chk("a5_hold", 32'(o_data), 32'hA5);
    last_good = 8'hA5;

    send(8'h00, 1'b1);
    tick(CPS);
    send(8'hFF, 1'b1);
    tick(20);
    check_events("b2b");
    last_good = 8'hFF;

    busy_cnt = 0;
    i_rx = 1'b0;
    tick(3);
    i_rx = 1'b1;
    tick(30);
    chk("glitch_busy_cycles", busy_cnt, HALF);
    chk("glitch_busy_end", 32'(o_busy), 32'h0);
    check_events("glitch");

    send(8'h3C, 1'b0);
    tick(40);
    chk("break_busy", 32'(o_busy), 32'h1);
    chk("break_data_hold", 32'(o_data), 32'(last_good));
    i_rx = 1'b1;
    tick(30);
    chk("break_release_busy", 32'(o_busy), 32'h0);
    check_events("ferr");
    send(8'hC3, 1'b1);
    tick(20);
    check_events("after_break");
    last_good = 8'hC3;

    b = 8'h55;
    i_rx = 1'b0;
    tick(CPS);
    for (int k = 0; k < 4; k++) begin
      i_rx = b[k];
      tick(CPS);
    end
    i_rx = b[4];
    tick(CPS / 2);
    i_reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(o_busy), 32'h0);
    chk("midrst_data", 32'(o_data), 32'h00);
    last_good = 8'h00;
    tick(3);
    i_rx = 1'b1;
    i_reset_n = 1'b1;
    tick(10);
    check_events("midrst_drop");
    send(8'h81, 1'b1);
    tick(20);
    check_events("midrst_81");

    i_rx = 1'b0;
    i_reset_n = 1'b0;
    tick(3);
    i_reset_n = 1'b1;
    busy_cnt = 0;
    tick(50);
    chk("lowrst_busy_cycles", busy_cnt, 0);
    check_events("lowrst_quiet");
    i_rx = 1'b1;
    tick(CPS);
    send(8'h5A, 1'b1);
    tick(20);
    check_events("lowrst_5a");

    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      gap = (i % 3 == 0) ? 0 : int'($urandom_range(1, 24));
      send(b, 1'b1);
      tick(gap);
      last_good = b;
    end
    tick(20);
    check_events("random");
    chk("random_last", 32'(o_data), 32'(last_good));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
